// File: rtl/reg_file_serial_master.sv
// Serial master for the register file: turns parallel read/write requests into a
// strobe + 8-bit address + 8-bit data serial frame on DIN and returns one response per request.
module reg_file_serial_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WR,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic                  RSP_WR,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  WR_EN,
    output logic                  RD_EN,
    output logic                  DIN,
    input  logic                  DOUT
);

    localparam int          TX_WIDTH   = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [4:0]  FLUSH_LAST = 5'd17;
    localparam logic [3:0]  BIT_LAST   = 4'd7;
    localparam logic [3:0]  GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        STROBE,
        ADDR,
        DATA,
        RSP,
        GAP
    } state_t;

    state_t                state;
    logic [4:0]            flush_cnt;
    logic [3:0]            bit_cnt;
    logic [3:0]            gap_cnt;
    logic                  wr_q;
    logic [TX_WIDTH-1:0]   tx_sh;
    logic [DATA_WIDTH-2:0] rx_sh;

    // tx_sh holds address then data (zero for reads) and is shifted out MSB-first,
    // so DIN naturally reads 0 during the data phase of a read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            wr_q      <= 1'b0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WR    <= 1'b0;
            RSP_RDATA <= '0;
            WR_EN     <= 1'b0;
            RD_EN     <= 1'b0;
            DIN       <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            WR_EN     <= 1'b0;
            RD_EN     <= 1'b0;
            DIN       <= 1'b0;
            case (state)
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state     <= IDLE;
                        REQ_READY <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + 5'd1;
                    end
                end
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        wr_q      <= REQ_WR;
                        tx_sh     <= {REQ_ADDR, (REQ_WR ? REQ_WDATA : {DATA_WIDTH{1'b0}})};
                        REQ_READY <= 1'b0;
                        WR_EN     <= REQ_WR;
                        RD_EN     <= !REQ_WR;
                        state     <= STROBE;
                    end
                end
                STROBE: begin
                    DIN     <= tx_sh[TX_WIDTH-1];
                    tx_sh   <= tx_sh << 1;
                    bit_cnt <= '0;
                    state   <= ADDR;
                end
                ADDR: begin
                    DIN   <= tx_sh[TX_WIDTH-1];
                    tx_sh <= tx_sh << 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (!wr_q) begin
                        rx_sh <= {rx_sh[DATA_WIDTH-3:0], DOUT};
                    end
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        RSP_VALID <= 1'b1;
                        RSP_WR    <= wr_q;
                        RSP_RDATA <= wr_q ? {DATA_WIDTH{1'b0}} : {rx_sh, DOUT};
                        state     <= RSP;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        DIN     <= tx_sh[TX_WIDTH-1];
                        tx_sh   <= tx_sh << 1;
                    end
                end
                RSP: begin
                    gap_cnt <= '0;
                    if (GAP_CYCLES == 0) begin
                        state     <= IDLE;
                        REQ_READY <= 1'b1;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= IDLE;
                        REQ_READY <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                    REQ_READY <= 1'b0;
                end
            endcase
        end
    end

endmodule
